data_mem_ctrl: RTL and testbench

//  Responder for the CPU data port: decodes data_addr/read_m/write_m/out_m and returns in_m.

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/mmio_regs.sv | 63 ++++++
 rtl/data_mem_ctrl.sv | 88 ++++++++
 tb/tb_data_mem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-port controller: I/O map and FSM state type.
package cpu_mem_pkg;

    // First I/O address; RAM occupies 0 .. IO_BASE-1
    localparam logic [14:0] IO_BASE = 15'h6000;

    // I/O register offsets relative to IO_BASE
    localparam logic [14:0] IO_SW  = 15'd0;
    localparam logic [14:0] IO_LED = 15'd1;
    localparam logic [14:0] IO_CYC = 15'd2;

    typedef enum logic {
        IDLE,
        RD_VALID
    } dmem_state_t;

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped I/O block: synchronised switch input, LED register and a
// free-running 16-bit cycle counter, selected by offset from the I/O base.
module mmio_regs
    import cpu_mem_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LED_W       = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [14:0]       offset,
    input  logic              we,
    input  logic [LED_W-1:0]  wdata,
    input  logic [3:0]        sw,
    output logic [15:0]       rdata,
    output logic [LED_W-1:0]  leds
);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [LED_W-1:0]            leds_q;
    logic [15:0]                 cyc_q;

    // Switch synchronizer: stage 0 samples the pins, the last stage is read
    always_ff @(posedge clk) begin
        if (!resetN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
        end
    end

    // LED register, loaded by a write to its offset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            leds_q <= '0;
        end else if (we && (offset == IO_LED)) begin
            leds_q <= wdata;
        end
    end

    // Free-running cycle counter; wraps naturally and keeps counting during stalls
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rdata = '0;
        case (offset)
            IO_SW:   rdata = {12'h000, sync_q[SYNC_STAGES-1]};
            IO_LED:  rdata = 16'(leds_q);
            IO_CYC:  rdata = cyc_q;
            default: rdata = '0;
        endcase
    end

    assign leds = leds_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU data-port responder: decodes RAM vs I/O, stalls the CPU for the one-cycle
// latency of the synchronous data RAM and muxes read data back onto in_m.
module data_mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter logic [14:0] IO_BASE     = cpu_mem_pkg::IO_BASE,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LED_W       = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [14:0]       data_addr,
    input  logic              read_m,
    input  logic              write_m,
    input  logic [15:0]       out_m,
    output logic [15:0]       in_m,
    output logic              stall,
    output logic [14:0]       ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic [3:0]        SW,
    output logic [LED_W-1:0]  leds
);

    dmem_state_t state_q;
    logic        is_ram;
    logic [14:0] io_offset;
    logic [15:0] io_rdata;
    logic        io_we;

    assign is_ram    = (data_addr < IO_BASE);
    // Only meaningful when is_ram is low; RAM addresses wrap here but are never used
    assign io_offset = data_addr - IO_BASE;
    assign io_we     = write_m && !is_ram;

    // RAM port follows the CPU address directly; the CPU holds it across the stall
    assign ram_addr  = data_addr;
    assign ram_wdata = out_m;
    assign ram_we    = write_m && is_ram;

    // Stall only on the first cycle of a RAM read; no path from read data
    assign stall = resetN && (state_q == IDLE) && read_m && is_ram;

    // Read FSM: one RD_VALID cycle after each stalled RAM read
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (read_m && is_ram) begin
                        state_q <= RD_VALID;
                    end
                end
                RD_VALID: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    // Read data: RAM data in RD_VALID, I/O data combinationally, zero otherwise
    always_comb begin
        in_m = '0;
        if (!resetN) begin
            in_m = '0;
        end else if (state_q == RD_VALID) begin
            in_m = ram_rdata;
        end else if (read_m && !is_ram) begin
            in_m = io_rdata;
        end
    end

    mmio_regs #(
        .SYNC_STAGES (SYNC_STAGES),
        .LED_W       (LED_W)
    ) u_mmio_regs (
        .clk    (clk),
        .resetN (resetN),
        .offset (io_offset),
        .we     (io_we),
        .wdata  (out_m[LED_W-1:0]),
        .sw     (SW),
        .rdata  (io_rdata),
        .leds   (leds)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: CPU-like driver, RAM macro model, transaction
// reference model and a scoreboard monitor that checks each completed access.
module tb_data_mem_ctrl;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LED_W       = 4;
    localparam logic [14:0] IOB         = 15'h6000;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic [14:0]       data_addr = '0;
    logic              read_m = 1'b0;
    logic              write_m = 1'b0;
    logic [15:0]       out_m = '0;
    logic [15:0]       in_m;
    logic              stall;
    logic [14:0]       ram_addr;
    logic              ram_we;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata = '0;
    logic [3:0]        sw_pins = '0;
    logic [LED_W-1:0]  leds;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .IO_BASE     (IOB),
        .SYNC_STAGES (SYNC_STAGES),
        .LED_W       (LED_W)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .data_addr (data_addr),
        .read_m    (read_m),
        .write_m   (write_m),
        .out_m     (out_m),
        .in_m      (in_m),
        .stall     (stall),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .SW        (sw_pins),
        .leds      (leds)
    );

    // Synchronous RAM macro: read-first, data valid one cycle after the address
    logic [15:0] ram_mem [0:32767];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Reference state
    logic [15:0]      ref_mem [0:32767];
    logic [LED_W-1:0] ref_leds = '0;
    logic [3:0]       sw_at [0:131071];
    int               tick = 0;
    int               rst_tick = 0;

    // Time base: edge index, switch value at each edge, last edge seen in reset
    always @(posedge clk) begin
        tick <= tick + 1;
        sw_at[tick + 1] <= sw_pins;
        if (!resetN) rst_tick <= tick + 1;
    end

    typedef struct {
        string       name;
        logic [15:0] data;
        int          stalls;
        bit          we;
        logic [14:0] waddr;
        logic [15:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cyc_model();
        return 16'(tick - rst_tick);
    endfunction

    // Value the CPU should see when reading address a at the current cycle
    function automatic logic [15:0] model_read(input logic [14:0] a);
        logic [14:0] off;
        if (a < IOB) return ref_mem[a];
        off = a - IOB;
        case (off)
            15'd0: begin
                if (tick - rst_tick < int'(SYNC_STAGES)) return 16'h0000;
                return {12'h000, sw_at[tick - int'(SYNC_STAGES) + 1]};
            end
            15'd1:   return 16'(ref_leds);
            15'd2:   return cyc_model();
            default: return 16'h0000;
        endcase
    endfunction

    // Issue one CPU access; called at posedge+1, returns at posedge+1 after completion
    task automatic issue(input logic [14:0] addr, input bit rd, input bit wr,
                         input logic [15:0] wd, input string name);
        exp_t e;
        int   n;
        bit   ram;
        bit   rmw;
        ram      = (addr < IOB);
        rmw      = rd && wr && ram;
        e.name   = name;
        e.data   = rd ? model_read(addr) : 16'h0000;
        e.stalls = (rd && ram) ? 1 : 0;
        e.we     = wr && ram;
        e.waddr  = addr;
        e.wdata  = rmw ? e.data + 16'd1 : wd;
        if (wr) begin
            if (ram) ref_mem[addr] = e.wdata;
            else if (addr == IOB + 15'd1) ref_leds = e.wdata[LED_W-1:0];
        end
        exp_q.push_back(e);

        data_addr = addr;
        read_m    = rd;
        write_m   = wr && !rmw;
        out_m     = wd;
        #1;
        n = 0;
        while (stall && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL %s stall_timeout: got stall=1 after %0d cycles, expected 0", name, n);
        end
        // Read-modify-write: CPU derives the write data from this cycle's in_m
        if (rmw) begin
            write_m = 1'b1;
            out_m   = in_m + 16'd1;
        end
        @(posedge clk);
        #1;
        read_m  = 1'b0;
        write_m = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: an access completes on a non-stalled cycle with read_m or write_m
    int stall_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!resetN) begin
            stall_run = 0;
        end else if (stall) begin
            stall_run++;
        end else if (read_m || write_m) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access: got access at 0x%0h, expected none", data_addr);
            end else begin
                e = exp_q.pop_front();
                check({e.name, " in_m"}, in_m, e.data);
                check({e.name, " stalls"}, stall_run, e.stalls);
                check({e.name, " ram_we"}, ram_we, e.we);
                if (e.we) begin
                    check({e.name, " ram_wdata"}, ram_wdata, e.wdata);
                    check({e.name, " ram_addr"}, ram_addr, e.waddr);
                end
            end
            stall_run = 0;
        end
    end

    logic [14:0] io_tab [0:5];
    int unsigned k;
    logic [14:0] ra;

    initial begin
        io_tab[0] = 15'h6000; io_tab[1] = 15'h6001; io_tab[2] = 15'h6002;
        io_tab[3] = 15'h6003; io_tab[4] = 15'h7000; io_tab[5] = 15'h7FFF;
        for (int i = 0; i < 32768; i++) begin
            ref_mem[i] = 16'($urandom);
            ram_mem[i] <= ref_mem[i];
        end
        ref_mem[16] = 16'h1234; ram_mem[16] <= 16'h1234;
        ref_mem[5]  = 16'h0007; ram_mem[5]  <= 16'h0007;

        // Reset: a RAM read presented during reset must not stall or return data
        resetN    = 1'b0;
        data_addr = 15'h0010;
        read_m    = 1'b1;
        idle(3);
        check("reset stall", stall, 1'b0);
        check("reset in_m", in_m, 16'h0000);
        check("reset leds", leds, 4'h0);
        read_m = 1'b0;
        resetN = 1'b1;

        // RAM read with one stall
        issue(15'h0010, 1, 0, 16'h0, "ram_read_0x10");
        // Read-modify-write M=M+1, then read back
        issue(15'h0005, 1, 1, 16'h0, "rmw_0x5");
        issue(15'h0005, 1, 0, 16'h0, "readback_0x5");
        // LED write and zero-stall readback
        issue(15'h6001, 0, 1, 16'h000A, "led_write");
        check("led_port", leds, 4'hA);
        issue(15'h6001, 1, 0, 16'h0, "led_read");
        // Switch synchronizer lag
        idle(3);
        sw_pins = 4'b1011;
        for (int i = 0; i < 4; i++) issue(15'h6000, 1, 0, 16'h0, "sw_read");
        // Cycle counter, ten cycles apart
        issue(15'h6002, 1, 0, 16'h0, "cyc_read_a");
        idle(9);
        issue(15'h6002, 1, 0, 16'h0, "cyc_read_b");
        // Unmapped and read-only I/O
        issue(15'h7000, 0, 1, 16'hFFFF, "unmapped_write");
        issue(15'h7000, 1, 0, 16'h0, "unmapped_read");
        issue(15'h6000, 0, 1, 16'hFFFF, "sw_write_ignored");
        issue(15'h6001, 1, 0, 16'h0, "led_unchanged");
        issue(15'h6003, 1, 0, 16'h0, "io_gap_read");
        // RAM/I-O boundary
        issue(15'h5FFF, 1, 0, 16'h0, "ram_top_read");
        issue(15'h5FFF, 0, 1, 16'hBEEF, "ram_top_write");
        issue(15'h5FFF, 1, 0, 16'h0, "ram_top_readback");

        // Randomised traffic
        for (int i = 0; i < 1000; i++) begin
            k  = $urandom_range(0, 9);
            ra = ($urandom_range(0, 7) == 0) ? 15'h5FFF : 15'($urandom_range(0, 63));
            case (k)
                0, 1, 2: issue(ra, 1, 0, 16'h0, "rnd_ram_read");
                3, 4:    issue(ra, 0, 1, 16'($urandom), "rnd_ram_write");
                5:       issue(ra, 1, 1, 16'h0, "rnd_rmw");
                6, 7:    issue(io_tab[$urandom_range(0, 5)], 1, 0, 16'h0, "rnd_io_read");
                8:       issue(io_tab[$urandom_range(0, 5)], 0, 1, 16'($urandom), "rnd_io_write");
                default: begin
                    sw_pins = 4'($urandom);
                    idle($urandom_range(1, 3));
                end
            endcase
        end

        // Reset while in RD_VALID: pending read is dropped
        data_addr = 15'h0020;
        read_m    = 1'b1;
        write_m   = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        check("rst_rdvalid stall", stall, 1'b0);
        check("rst_rdvalid in_m", in_m, 16'h0000);
        @(posedge clk);
        #1;
        read_m   = 1'b0;
        resetN   = 1'b1;
        ref_leds = '0;
        check("rst_rdvalid leds", leds, 4'h0);
        issue(15'h0020, 1, 0, 16'h0, "post_reset_read");
        issue(15'h7000, 1, 0, 16'h0, "post_reset_unmapped_read");
        issue(15'h7000, 0, 1, 16'h1234, "post_reset_unmapped_write");
        issue(15'h6001, 1, 0, 16'h0, "post_reset_led_read");

        // Cycle counter wrap FFFF -> 0000
        begin
            int n;
            n = 0;
            while (cyc_model() != 16'hFFFF && n < 70000) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        issue(15'h6002, 1, 0, 16'h0, "cyc_ffff");
        issue(15'h6002, 1, 0, 16'h0, "cyc_wrap");

        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
